nibble_serial_adder_ctrl: RTL



---
 rtl/nibble_serial_adder_ctrl_if.sv | 34 +++
 rtl/nibble_serial_adder_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshakes plus the link to the external 4-bit adder.
interface nibble_serial_adder_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [3:0]   add_x;
  logic [3:0]   add_y;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;

  // Sequencer side
  modport slave (
    input  in_valid, a_in, b_in, cin, out_ready, add_s, add_cout,
    output in_ready, out_valid, sum, cout, ovf, add_x, add_y, add_cin
  );

  // Producer / consumer / adder side
  modport master (
    output in_valid, a_in, b_in, cin, out_ready, add_s, add_cout,
    input  in_ready, out_valid, sum, cout, ovf, add_x, add_y, add_cin
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder sequencer: feeds an external 4-bit adder one nibble per cycle,
// carrying between nibbles, with valid/ready on operands and result.
module nibble_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input logic                      clk,
  input logic                      resetn,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sum_q;
  logic           carry_q;
  logic           cout_q;
  logic           ovf_q;
  logic [IW-1:0]  idx;
  logic [IW+1:0]  shamt;
  logic [3:0]     nib_a;
  logic [3:0]     nib_b;
  logic           last;
  logic           in_rdy;
  logic           out_vld;
  logic [3:0]     x;
  logic [3:0]     y;
  logic           ci;

  // Current nibble position as a bit offset
  assign shamt = {idx, 2'b00};
  assign nib_a = 4'(a_q >> shamt);
  assign nib_b = 4'(b_q >> shamt);
  assign last  = (idx == IW'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    x         = 4'h0;
    y         = 4'h0;
    ci        = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        x  = nib_a;
        y  = nib_b;
        ci = carry_q;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-nibble sum/carry update, final flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            carry_q <= bus.cin;
            sum_q   <= '0;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_q   <= (sum_q & ~(W'(4'hF) << shamt)) | (W'(bus.add_s) << shamt);
          carry_q <= bus.add_cout;
          if (last) begin
            cout_q <= bus.add_cout;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (bus.add_s[3] != a_q[W-1]);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.add_x     = x;
  assign bus.add_y     = y;
  assign bus.add_cin   = ci;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule
